// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer: multicycle load/store sequencer for the LC-3b memory port.
// Accepts one LDR/LDB/LDI/STR/STB/STI request at a time. It fetches the pointer
// for indirect ops and steers byte lanes for LDB/STB. Load data is returned with
// a one-cycle done pulse.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req_*              request handshake (valid/ready, opcode, address, store data)
//   done, rdata        completion pulse and load result (held until next load)
//   mem_*              unified memory port (strobes, address, byte enables, data, resp)
module lc3b_mem_sequencer #(
   parameter bit SEXT_LDB = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        done,
   output logic [15:0] rdata,
   output logic [15:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp
);

   localparam int unsigned DW  = 16;
   localparam int unsigned OPW = 4;
   localparam int unsigned BW  = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_IND  = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [OPW-1:0] OP_LDB = 4'b0010;
   localparam logic [OPW-1:0] OP_STB = 4'b0011;
   localparam logic [OPW-1:0] OP_LDR = 4'b0110;
   localparam logic [OPW-1:0] OP_STR = 4'b0111;
   localparam logic [OPW-1:0] OP_LDI = 4'b1010;
   localparam logic [OPW-1:0] OP_STI = 4'b1011;

   logic [1:0]     state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [DW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic [DW-1:0]  rdata_d;
   logic           req_is_mem, req_is_ind, op_is_load;
   logic [DW-1:0]  word_addr;
   logic [BW-1:0]  ld_byte;
   logic [DW-1:0]  ld_byte_ext;

   // Request / latched-op decode
   assign req_is_mem = (req_op == OP_LDR) || (req_op == OP_LDB) || (req_op == OP_LDI) ||
                       (req_op == OP_STR) || (req_op == OP_STB) || (req_op == OP_STI);
   assign req_is_ind = (req_op == OP_LDI) || (req_op == OP_STI);
   assign op_is_load = (op_q == OP_LDR) || (op_q == OP_LDB) || (op_q == OP_LDI);

   // Word ops ignore addr[0]; it only selects the lane for LDB/STB
   assign word_addr   = {addr_q[DW-1:1], 1'b0};
   assign ld_byte     = addr_q[0] ? mem_rdata[DW-1:BW] : mem_rdata[BW-1:0];
   assign ld_byte_ext = SEXT_LDB ? {{(DW-BW){ld_byte[BW-1]}}, ld_byte}
                                 : {{(DW-BW){1'b0}}, ld_byte};

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata   <= rdata_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_is_mem) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = req_is_ind ? S_IND : S_ACC;
            end
         end
         S_IND: begin
            // Fetched pointer replaces the address for the data access
            if (mem_resp) begin
               addr_d  = mem_rdata;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            if (mem_resp) begin
               if (op_is_load) begin
                  rdata_d = (op_q == OP_LDB) ? ld_byte_ext : mem_rdata;
               end
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state only, so strobes drop with an async reset
   always_comb begin
      req_ready       = 1'b0;
      done            = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_byte_enable = 2'b00;
      mem_wdata       = '0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_IND: begin
            mem_read        = 1'b1;
            mem_address     = word_addr;
            mem_byte_enable = 2'b11;
         end
         S_ACC: begin
            mem_address = word_addr;
            if (op_is_load) begin
               mem_read        = 1'b1;
               mem_byte_enable = 2'b11;
            end else if (op_q == OP_STB) begin
               mem_write       = 1'b1;
               mem_wdata       = {wdata_q[BW-1:0], wdata_q[BW-1:0]};
               mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
            end else begin
               mem_write       = 1'b1;
               mem_wdata       = wdata_q;
               mem_byte_enable = 2'b11;
            end
         end
         default: done = 1'b1;
      endcase
   end

endmodule
